// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} tx_state_t;

  localparam int PAR_NONE  = 0;
  localparam int PAR_EVEN  = 1;
  localparam int PAR_ODD   = 2;

  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead circular command buffer with registered count/full/empty and a sticky overflow flag.
module cmd_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rd_en,
  input  logic                     i_flush,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_countNext;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic              w_push;
  logic              w_pop;

  // A pop in the same cycle frees the slot, so a write while full is still accepted then.
  assign w_pop       = i_rd_en && !r_empty;
  assign w_push      = i_wr_en && (!r_full || w_pop);
  assign w_countNext = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wrPtr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= w_countNext;
      r_full  <= (w_countNext == FULL_CNT);
      r_empty <= (w_countNext == '0);
      if (i_wr_en && r_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_rd_data  = r_mem[r_rdPtr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_cmd_seq.sv
// Queues command bytes and serialises them back-to-back as UART frames with
// programmable bit period, parity and inter-frame gap.
module uart_cmd_seq
  import uart_cmd_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int BAUD_DIV = 2604,
  parameter int GAP_BITS = 0,
  parameter int PARITY   = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic                   i_flush,
  input  logic                   i_pause,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int BAUD_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W   = $clog2(DATA_W + 1);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);
  localparam bit HAS_GAP = (GAP_BITS != 0);
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST  = GAP_CNT_W'(GAP_BITS - 1);

  tx_state_t             r_state;
  tx_state_t             w_stateNext;
  logic [BAUD_W-1:0]     r_baudCnt;
  logic [BAUD_W-1:0]     w_baudNext;
  logic [BIT_W-1:0]      r_bitCnt;
  logic [GAP_CNT_W-1:0]  r_gapCnt;
  logic [DATA_W-1:0]     r_shift;
  logic [DATA_W-1:0]     w_shiftNext;
  logic [DATA_W-1:0]     w_fifoData;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_frameDone;
  logic                  w_txNext;
  logic                  w_busyNext;
  logic                  w_frameDoneNext;
  logic                  w_tick;
  logic                  w_canStart;
  logic                  w_frameEnd;
  logic                  w_pop;
  logic                  w_fifoEmpty;

  cmd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_rd_en    (w_pop),
    .i_flush    (i_flush),
    .o_rd_data  (w_fifoData),
    .o_full     (o_full),
    .o_empty    (w_fifoEmpty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  // The end of a frame (stop or gap) can launch the next one directly, so queued
  // frames follow each other with no idle clock in between.
  assign w_tick     = (r_state != IDLE) && (r_baudCnt == BAUD_LAST);
  assign w_canStart = !w_fifoEmpty && !i_pause;
  assign w_frameEnd = w_tick && (((r_state == STOP) && !HAS_GAP) ||
                                 ((r_state == GAP) && (r_gapCnt == GAP_LAST)));
  assign w_pop      = w_canStart && ((r_state == IDLE) || w_frameEnd);

  assign w_baudNext  = ((r_state == IDLE) || w_tick) ? '0 : r_baudCnt + BAUD_W'(1);
  assign w_shiftNext = w_pop ? w_fifoData :
                       ((r_state == DATA) && w_tick) ? (r_shift >> 1) : r_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (w_canStart) w_stateNext = START;
      START: if (w_tick) w_stateNext = DATA;
      DATA: begin
        if (w_tick && (r_bitCnt == BIT_LAST)) begin
          if (HAS_PAR) w_stateNext = PAR;
          else         w_stateNext = STOP;
        end
      end
      PAR: if (w_tick) w_stateNext = STOP;
      STOP: begin
        if (w_tick) begin
          if (HAS_GAP)         w_stateNext = GAP;
          else if (w_canStart) w_stateNext = START;
          else                 w_stateNext = IDLE;
        end
      end
      GAP: begin
        if (w_frameEnd) begin
          if (w_canStart) w_stateNext = START;
          else            w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered TX changes on the
  // same edge as the state it belongs to.
  always_comb begin
    w_txNext        = 1'b1;
    w_busyNext      = (w_stateNext != IDLE);
    w_frameDoneNext = (w_stateNext == STOP) && (w_baudNext == BAUD_LAST);
    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
      PAR:     w_txNext = r_parity;
      default: w_txNext = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_tx        <= w_txNext;
      r_busy      <= w_busyNext;
      r_frameDone <= w_frameDoneNext;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_gapCnt  <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
    end else begin
      r_baudCnt <= w_baudNext;
      r_shift   <= w_shiftNext;
      if (r_state != DATA) begin
        r_bitCnt <= '0;
      end else if (w_tick) begin
        r_bitCnt <= r_bitCnt + BIT_W'(1);
      end
      if (r_state != GAP) begin
        r_gapCnt <= '0;
      end else if (w_tick) begin
        r_gapCnt <= r_gapCnt + GAP_CNT_W'(1);
      end
      if (w_pop) begin
        r_parity <= (PARITY == PAR_ODD) ? ~^w_fifoData : ^w_fifoData;
      end
    end
  end

  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frameDone;
  assign o_empty      = w_fifoEmpty;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Directed bench for uart_cmd_seq: unit A (no parity, no gap, depth 4), unit B (odd parity, 2-bit gap).
module tb_uart_cmd_seq;

  localparam int BAUD = 4;

  logic       clk;
  logic       rst;

  logic       wrA, flushA, pauseA;
  logic [7:0] dataA;
  logic       txA, busyA, fdA, fullA, emptyA, ovA;
  logic [2:0] countA;

  logic       wrB, flushB, pauseB;
  logic [7:0] dataB;
  logic       txB, busyB, fdB, fullB, emptyB, ovB;
  logic [3:0] countB;

  int checkCount = 0;
  int passCount  = 0;

  logic [7:0] t4Data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  uart_cmd_seq #(
    .DATA_W(8), .DEPTH(4), .BAUD_DIV(BAUD), .GAP_BITS(0), .PARITY(0)
  ) dutA (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wrA), .i_wr_data(dataA),
    .i_flush(flushA), .i_pause(pauseA), .o_tx(txA), .o_busy(busyA),
    .o_frame_done(fdA), .o_full(fullA), .o_empty(emptyA),
    .o_count(countA), .o_overflow(ovA)
  );

  uart_cmd_seq #(
    .DATA_W(8), .DEPTH(8), .BAUD_DIV(BAUD), .GAP_BITS(2), .PARITY(2)
  ) dutB (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wrB), .i_wr_data(dataB),
    .i_flush(flushB), .i_pause(pauseB), .o_tx(txB), .o_busy(busyB),
    .o_frame_done(fdB), .o_full(fullB), .o_empty(emptyB),
    .o_count(countB), .o_overflow(ovB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want normal finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int unit, input logic [7:0] data);
    if (unit == 0) begin
      wrA = 1'b1; dataA = data;
    end else begin
      wrB = 1'b1; dataB = data;
    end
    step();
    wrA = 1'b0;
    wrB = 1'b0;
  endtask

  // Called at the sample just after the start edge (k=0); returns at the last clock of the gap/stop.
  task automatic watchFrame(input int unit, input logic [7:0] data, input int parMode,
                            input int gapBits, input string tag);
    int   frameLen;
    int   totalLen;
    logic expTx;
    logic parBit;
    frameLen = (10 + ((parMode != 0) ? 1 : 0)) * BAUD;
    totalLen = frameLen + gapBits * BAUD;
    parBit   = (parMode == 2) ? ~^data : ^data;
    for (int k = 0; k < totalLen; k++) begin
      if (k > 0) step();
      if (k < BAUD)                           expTx = 1'b0;
      else if (k < 9 * BAUD)                  expTx = data[(k - BAUD) / BAUD];
      else if (parMode != 0 && k < 10 * BAUD) expTx = parBit;
      else                                    expTx = 1'b1;
      checkOutput($sformatf("%s tx k=%0d", tag, k), 32'(unit == 0 ? txA : txB), 32'(expTx));
      checkOutput($sformatf("%s frame_done k=%0d", tag, k), 32'(unit == 0 ? fdA : fdB),
                  32'(k == frameLen - 1));
      checkOutput($sformatf("%s busy k=%0d", tag, k), 32'(unit == 0 ? busyA : busyB), 32'(1));
    end
  endtask

  initial begin
    rst = 1'b1;
    wrA = 1'b0; dataA = '0; flushA = 1'b0; pauseA = 1'b0;
    wrB = 1'b0; dataB = '0; flushB = 1'b0; pauseB = 1'b0;
    step(); step();

    checkOutput("reset tx", 32'(txA), 32'(1));
    checkOutput("reset busy", 32'(busyA), 32'(0));
    checkOutput("reset frame_done", 32'(fdA), 32'(0));
    checkOutput("reset full", 32'(fullA), 32'(0));
    checkOutput("reset empty", 32'(emptyA), 32'(1));
    checkOutput("reset count", 32'(countA), 32'(0));
    checkOutput("reset overflow", 32'(ovA), 32'(0));
    checkOutput("reset B tx", 32'(txB), 32'(1));
    rst = 1'b0;
    step();

    $display("[TB] single frame A5");
    applyStimulus(0, 8'hA5);
    checkOutput("t1 tx before pop", 32'(txA), 32'(1));
    checkOutput("t1 empty after write", 32'(emptyA), 32'(0));
    checkOutput("t1 count after write", 32'(countA), 32'(1));
    step();
    checkOutput("t1 count after pop", 32'(countA), 32'(0));
    watchFrame(0, 8'hA5, 0, 0, "t1");
    step();
    checkOutput("t1 busy after", 32'(busyA), 32'(0));
    checkOutput("t1 tx after", 32'(txA), 32'(1));

    $display("[TB] three back-to-back frames");
    pauseA = 1'b1;
    applyStimulus(0, 8'h06);
    applyStimulus(0, 8'h0A);
    applyStimulus(0, 8'h05);
    checkOutput("t2 count 3", 32'(countA), 32'(3));
    pauseA = 1'b0;
    step();
    checkOutput("t2 count 2", 32'(countA), 32'(2));
    watchFrame(0, 8'h06, 0, 0, "t2a");
    step();
    checkOutput("t2 count 1", 32'(countA), 32'(1));
    watchFrame(0, 8'h0A, 0, 0, "t2b");
    step();
    checkOutput("t2 count 0", 32'(countA), 32'(0));
    watchFrame(0, 8'h05, 0, 0, "t2c");
    step();
    checkOutput("t2 busy falls", 32'(busyA), 32'(0));

    $display("[TB] odd parity with gap");
    applyStimulus(1, 8'h07);
    checkOutput("t3 tx before pop", 32'(txB), 32'(1));
    step();
    watchFrame(1, 8'h07, 2, 2, "t3");
    step();
    checkOutput("t3 busy falls", 32'(busyB), 32'(0));
    checkOutput("t3 tx idle", 32'(txB), 32'(1));

    $display("[TB] paused fill and overflow");
    pauseA = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, t4Data[i]);
      if (i == 3) begin
        checkOutput("t4 full after 4", 32'(fullA), 32'(1));
        checkOutput("t4 count after 4", 32'(countA), 32'(4));
        checkOutput("t4 no overflow yet", 32'(ovA), 32'(0));
      end
    end
    checkOutput("t4 count after 5", 32'(countA), 32'(4));
    checkOutput("t4 overflow set", 32'(ovA), 32'(1));
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t4 paused tx %0d", i), 32'(txA), 32'(1));
      checkOutput($sformatf("t4 paused busy %0d", i), 32'(busyA), 32'(0));
      step();
    end
    pauseA = 1'b0;
    step();
    checkOutput("t4 count after first pop", 32'(countA), 32'(3));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      watchFrame(0, t4Data[i], 0, 0, $sformatf("t4f%0d", i));
    end
    step();
    checkOutput("t4 busy done", 32'(busyA), 32'(0));
    checkOutput("t4 empty done", 32'(emptyA), 32'(1));
    checkOutput("t4 overflow sticky", 32'(ovA), 32'(1));

    $display("[TB] mid-frame flush");
    wrA = 1'b1; dataA = 8'h3C; step();
    dataA = 8'h5A; step();
    dataA = 8'h69; step();
    dataA = 8'h96; step();
    wrA = 1'b0;
    checkOutput("t5 count 3 queued", 32'(countA), 32'(3));
    for (int k = 3; k <= 40; k++) begin
      if (k == 10) flushA = 1'b1;
      step();
      flushA = 1'b0;
      if (k == 10) begin
        checkOutput("t5 empty after flush", 32'(emptyA), 32'(1));
        checkOutput("t5 count after flush", 32'(countA), 32'(0));
        checkOutput("t5 overflow cleared", 32'(ovA), 32'(0));
      end
      if (k == 26) checkOutput("t5 tx bit5", 32'(txA), 32'(1));
      if (k == 30) checkOutput("t5 tx bit6", 32'(txA), 32'(0));
      if (k == 39) checkOutput("t5 frame_done", 32'(fdA), 32'(1));
      if (k == 40) begin
        checkOutput("t5 busy after", 32'(busyA), 32'(0));
        checkOutput("t5 tx after", 32'(txA), 32'(1));
      end
    end
    for (int i = 0; i < 45; i++) begin
      step();
      checkOutput($sformatf("t5 quiet busy %0d", i), 32'(busyA), 32'(0));
    end

    $display("[TB] reset during data");
    wrA = 1'b1; dataA = 8'hC3; step();
    dataA = 8'h81; step();
    wrA = 1'b0;
    checkOutput("t6 count 1", 32'(countA), 32'(1));
    for (int k = 1; k <= 13; k++) step();
    checkOutput("t6 tx bit2 before rst", 32'(txA), 32'(0));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6 tx async", 32'(txA), 32'(1));
    checkOutput("t6 busy async", 32'(busyA), 32'(0));
    checkOutput("t6 count async", 32'(countA), 32'(0));
    checkOutput("t6 empty async", 32'(emptyA), 32'(1));
    step();
    rst = 1'b0;
    step();
    checkOutput("t6 idle after release", 32'(busyA), 32'(0));
    applyStimulus(0, 8'h5A);
    step();
    watchFrame(0, 8'h5A, 0, 0, "t6");
    step();
    checkOutput("t6 busy after", 32'(busyA), 32'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
